// File: rtl/crypto_job_scheduler_pkg.sv
// Shared definitions for the crypto job scheduler: function codes, core
// indices, FSM state encoding and the fn -> core select mapping.
package crypto_sched_pkg;

  localparam logic [1:0] FN_AES    = 2'b00;
  localparam logic [1:0] FN_BF     = 2'b01;
  localparam logic [1:0] FN_SHA256 = 2'b10;
  localparam logic [1:0] FN_SHA224 = 2'b11;

  localparam int CORE_AES  = 0;
  localparam int CORE_BF   = 1;
  localparam int CORE_SHA  = 2;
  localparam int NUM_CORES = 3;

  typedef logic [1:0] sched_state_t;
  localparam sched_state_t ST_IDLE = 2'd0;
  localparam sched_state_t ST_RUN  = 2'd1;
  localparam sched_state_t ST_RSP  = 2'd2;
  localparam sched_state_t ST_COOL = 2'd3;

  // One-hot core select for a function code; both SHA widths share one core.
  function automatic logic [NUM_CORES-1:0] fn_to_core_oh(input logic [1:0] fn);
    logic [NUM_CORES-1:0] oh;
    oh = '0;
    case (fn)
      FN_AES:               oh[CORE_AES] = 1'b1;
      FN_BF:                oh[CORE_BF]  = 1'b1;
      FN_SHA256, FN_SHA224: oh[CORE_SHA] = 1'b1;
      default:              oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/crypto_job_scheduler_if.sv
// Request/core/response bundle between the queue logic, the scheduler and
// the three crypto cores. slave = scheduler side, master = surroundings.
interface crypto_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  import crypto_sched_pkg::*;

  logic [NUM_REQ-1:0]   req_valid;
  logic [2*NUM_REQ-1:0] req_fn;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_CORES-1:0] core_start;
  logic                 sha_mode;
  logic [NUM_CORES-1:0] core_done;
  logic                 rsp_valid;
  logic [ID_W-1:0]      rsp_id;
  logic [1:0]           rsp_fn;
  logic                 rsp_err;
  logic                 busy;

  modport master (
    output req_valid, req_fn, core_done,
    input  req_ready, core_start, sha_mode, rsp_valid, rsp_id, rsp_fn, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_fn, core_done,
    output req_ready, core_start, sha_mode, rsp_valid, rsp_id, rsp_fn, rsp_err, busy
  );

endinterface

// File: rtl/crypto_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above rr_ptr,
// wrapping past NUM_REQ-1 back to 0.
module crypto_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any_req
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  // Scan offsets from far to near so the nearest requester overwrites last.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    any_req = |req;
    sum     = '0;
    idx     = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(off);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      idx = sum[ID_W-1:0];
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/crypto_job_scheduler.sv
// Shares the AES, Blowfish and SHA cores among NUM_REQ requesters, one job
// at a time, granting round-robin. Define CRYPTO_SCHED_WDOG_EN to build the
// RUN-state watchdog that aborts a hung core with rsp_err=1.
module crypto_job_scheduler
  import crypto_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 1023,
  parameter int TO_W        = 10
) (
  input  logic          clk,
  input  logic          rst,
  crypto_sched_if.slave bus
);

  sched_state_t         state_q;
  logic [ID_W-1:0]      rr_ptr_q;
  logic [ID_W-1:0]      id_q;
  logic [1:0]           fn_q;
  logic [NUM_REQ-1:0]   gnt;
  logic [ID_W-1:0]      gnt_id;
  logic [1:0]           gnt_fn;
  logic                 any_req;
  logic [NUM_CORES-1:0] sel_oh;
  logic                 done_hit;
  logic                 timeout;
  logic                 in_run;
  logic                 in_rsp;

  // The counter must be able to reach its budget value.
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (1 << TO_W)) begin : g_bad_timeout_cfg
    $error("TIMEOUT_CYC does not fit in TO_W bits");
  end

  crypto_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req     (bus.req_valid),
    .rr_ptr  (rr_ptr_q),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .any_req (any_req)
  );

  assign gnt_fn   = bus.req_fn[{gnt_id, 1'b0} +: 2];
  assign sel_oh   = fn_to_core_oh(fn_q);
  assign done_hit = |(bus.core_done & sel_oh);
  assign in_run   = (state_q == ST_RUN);
  assign in_rsp   = (state_q == ST_RSP);

`ifdef CRYPTO_SCHED_WDOG_EN
  logic [TO_W-1:0] cnt_q;
  logic            err_q;

  // Count RUN cycles; cleared outside RUN so each job starts at zero.
  always_ff @(posedge clk) begin
    if (rst)         cnt_q <= '0;
    else if (in_run) cnt_q <= cnt_q + 1'b1;
    else             cnt_q <= '0;
  end

  assign timeout = in_run && (cnt_q == TO_W'(TIMEOUT_CYC));

  // Abort flag for the response; a done in the timeout cycle wins.
  always_ff @(posedge clk) begin
    if (rst)         err_q <= 1'b0;
    else if (in_run) err_q <= timeout && !done_hit;
  end

  assign bus.rsp_err = in_rsp ? err_q : 1'b0;
`else
  assign timeout     = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  // Job FSM: grant in IDLE, hold core start in RUN, respond, then one
  // cooling cycle with every core held in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      fn_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (any_req) begin
          state_q  <= ST_RUN;
          id_q     <= gnt_id;
          fn_q     <= gnt_fn;
          rr_ptr_q <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end
        ST_RUN:  if (done_hit || timeout) state_q <= ST_RSP;
        ST_RSP:  state_q <= ST_COOL;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE && !rst) ? gnt : '0;
  assign bus.core_start = in_run ? sel_oh : '0;
  assign bus.sha_mode   = in_run && (fn_q == FN_SHA256);
  assign bus.rsp_valid  = in_rsp;
  assign bus.rsp_id     = in_rsp ? id_q : '0;
  assign bus.rsp_fn     = in_rsp ? fn_q : '0;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_crypto_job_scheduler.sv
// Bench for crypto_job_scheduler: reset checks, directed round-robin and
// SHA/reset/timeout sequences, a table of single jobs, and randomized job
// streams checked against a transaction-level round-robin model.
module tb_crypto_job_scheduler;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  crypto_sched_if #(.NUM_REQ(N), .ID_W(2)) bus ();

  crypto_job_scheduler #(
    .NUM_REQ     (N),
    .ID_W        (2),
    .TIMEOUT_CYC (15),
    .TO_W        (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int m_ptr  = 0;

  typedef struct {
    logic [3:0] rv;
    logic [7:0] fv;
    int         lat;
    logic [1:0] id;
    logic [2:0] start;
    logic       sha;
    logic [2:0] spur;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Core select from the fn table: AES bit0, BF bit1, either SHA bit2.
  function automatic logic [2:0] core_of(input logic [1:0] fn);
    case (fn)
      2'b00:   return 3'b001;
      2'b01:   return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '1;
    bus.req_fn    = 8'hE4;
    bus.core_done = '1;
    step();
    smp();
    chk("rst_req_ready",  bus.req_ready, 0);
    chk("rst_core_start", bus.core_start, 0);
    chk("rst_sha_mode",   bus.sha_mode, 0);
    chk("rst_rsp_valid",  bus.rsp_valid, 0);
    chk("rst_rsp_id",     bus.rsp_id, 0);
    chk("rst_rsp_fn",     bus.rsp_fn, 0);
    chk("rst_rsp_err",    bus.rsp_err, 0);
    chk("rst_busy",       bus.busy, 0);
    step();
    rst = 1'b0;
    bus.req_valid = '0;
    bus.core_done = '0;
    m_ptr = 0;
  endtask

  // One full job from the IDLE grant cycle through COOL; returns in the
  // cycle where the next grant may happen (3 cycles after done).
  task automatic do_job(input logic [3:0] rv, input logic [7:0] fv, input int lat,
                        input logic [1:0] eid, input logic [2:0] est, input logic esha,
                        input logic [2:0] spur, input bit hold);
    logic [1:0] efn;
    logic [3:0] g;
    efn = fv[2*eid +: 2];
    g   = 4'b0001 << eid;
    bus.req_valid = rv;
    bus.req_fn    = fv;
    smp();
    chk("grant", bus.req_ready, g);
    chk("idle_busy", bus.busy, 0);
    chk("idle_start", bus.core_start, 0);
    step();
    bus.req_valid = hold ? (rv & ~g) : 4'b0000;
    m_ptr = (int'(eid) + 1) % N;
    for (int k = 0; k <= lat; k++) begin
      bus.core_done = (k == lat) ? est : (spur & ~est);
      smp();
      chk("core_start", bus.core_start, est);
      chk("sha_mode", bus.sha_mode, esha);
      chk("run_rsp_valid", bus.rsp_valid, 0);
      chk("run_req_ready", bus.req_ready, 0);
      step();
    end
    bus.core_done = '0;
    smp();
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_id", bus.rsp_id, eid);
    chk("rsp_fn", bus.rsp_fn, efn);
    chk("rsp_err", bus.rsp_err, 0);
    chk("rsp_core_start", bus.core_start, 0);
    step();
    smp();
    chk("cool_rsp_valid", bus.rsp_valid, 0);
    chk("cool_core_start", bus.core_start, 0);
    chk("cool_req_ready", bus.req_ready, 0);
    chk("cool_busy", bus.busy, 1);
    step();
  endtask

  // Reference pick: pending requester with the smallest forward distance from the pointer.
  function automatic int model_pick(input logic [3:0] pend);
    int best, bd, d;
    best = -1;
    bd   = N;
    for (int i = 0; i < N; i++) begin
      if (pend[i]) begin
        d = (i - m_ptr + N) % N;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] pend;
    logic [7:0] fv_r;
    logic [1:0] fn;
    int         id, runc;

    tbl[0] = '{4'b0001, 8'h00, 0, 2'd0, 3'b001, 1'b0, 3'b000};
    tbl[1] = '{4'b0101, 8'h20, 2, 2'd2, 3'b100, 1'b1, 3'b111};
    tbl[2] = '{4'b1001, 8'h40, 5, 2'd3, 3'b010, 1'b0, 3'b000};
    tbl[3] = '{4'b1110, 8'h0C, 1, 2'd1, 3'b100, 1'b0, 3'b000};
    tbl[4] = '{4'b0011, 8'h01, 0, 2'd0, 3'b010, 1'b0, 3'b111};
    tbl[5] = '{4'b1111, 8'h08, 3, 2'd1, 3'b100, 1'b1, 3'b000};

    bus.req_valid = '0;
    bus.req_fn    = '0;
    bus.core_done = '0;

    do_reset();

    // Round-robin with everyone waiting, BF jobs, done 5 cycles after start.
    do_job(4'b1111, 8'h55, 5, 2'd0, 3'b010, 1'b0, 3'b000, 1'b1);
    do_job(4'b1110, 8'h55, 5, 2'd1, 3'b010, 1'b0, 3'b000, 1'b1);
    do_job(4'b1100, 8'h55, 5, 2'd2, 3'b010, 1'b0, 3'b000, 1'b1);
    do_job(4'b1000, 8'h55, 5, 2'd3, 3'b010, 1'b0, 3'b000, 1'b1);
    do_job(4'b1111, 8'h55, 5, 2'd0, 3'b010, 1'b0, 3'b000, 1'b0);

    // Single long AES job.
    do_job(4'b0001, 8'h00, 18, 2'd0, 3'b001, 1'b0, 3'b000, 1'b0);

    do_reset();
    for (int i = 0; i < 6; i++)
      do_job(tbl[i].rv, tbl[i].fv, tbl[i].lat, tbl[i].id, tbl[i].start, tbl[i].sha,
             tbl[i].spur, 1'b0);

    // SHA-224 on requester 2 with spurious done from the other cores.
    do_job(4'b0100, 8'h30, 4, 2'd2, 3'b100, 1'b0, 3'b011, 1'b0);

    // Reset in the middle of a BF job from requester 1 (pointer then 2).
    bus.req_valid = 4'b0010;
    bus.req_fn    = 8'h04;
    smp();
    chk("mid_grant", bus.req_ready, 4'b0010);
    step();
    bus.req_valid = '0;
    smp();
    chk("mid_start", bus.core_start, 3'b010);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_ptr = 0;
    smp();
    chk("mid_rst_start", bus.core_start, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_rsp", bus.rsp_valid, 0);
    step();
    smp();
    chk("mid_rst_rsp2", bus.rsp_valid, 0);
    step();
    do_job(4'b1010, 8'h44, 1, 2'd1, 3'b010, 1'b0, 3'b000, 1'b0);
    do_job(4'b1000, 8'h40, 2, 2'd3, 3'b010, 1'b0, 3'b000, 1'b0);

    // Hung core: no done at all.
    bus.req_valid = 4'b0001;
    bus.req_fn    = 8'h00;
    smp();
    chk("hang_grant", bus.req_ready, 4'b0001);
    step();
    bus.req_valid = '0;
    m_ptr = 1;
    runc = 0;
    while (runc < 40) begin
      smp();
      if (bus.rsp_valid) break;
      runc++;
      step();
    end
`ifdef CRYPTO_SCHED_WDOG_EN
    chk("wdog_cycles", runc, 16);
    chk("wdog_err", bus.rsp_err, 1);
    chk("wdog_id", bus.rsp_id, 0);
    step();
`else
    chk("no_wdog_wait", runc, 40);
    bus.core_done = 3'b001;
    step();
    bus.core_done = '0;
    smp();
    chk("late_rsp_valid", bus.rsp_valid, 1);
    chk("late_rsp_err", bus.rsp_err, 0);
    step();
`endif
    smp();
    chk("hang_cool_busy", bus.busy, 1);
    step();

    // Done in the 16th RUN cycle: coincides with the timeout point, err stays 0.
    do_job(4'b0001, 8'h00, 15, 2'd0, 3'b001, 1'b0, 3'b000, 1'b0);

    // Randomized job stream against the round-robin model.
    pend = '0;
    fv_r = '0;
    for (int j = 0; j < 60; j++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom % 3 == 0)) begin
          pend[i] = 1'b1;
          fv_r[2*i +: 2] = 2'($urandom);
        end
      end
      if (pend == 4'b0000) begin
        bus.req_valid = '0;
        smp();
        chk("rnd_idle_ready", bus.req_ready, 0);
        chk("rnd_idle_busy", bus.busy, 0);
        step();
        id = $urandom_range(0, N - 1);
        pend[id] = 1'b1;
        fv_r[2*id +: 2] = 2'($urandom);
      end
      id = model_pick(pend);
      fn = fv_r[2*id +: 2];
      do_job(pend, fv_r, $urandom_range(0, 6), 2'(id), core_of(fn), (fn == 2'b10),
             3'($urandom), 1'b1);
      pend[id] = 1'b0;
    end

    bus.req_valid = '0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
